// File: rtl/cpu_id_stage.sv
// rtl/cpu_id_stage.sv - Decode stage: control decoder, register array, load-use interlock, ID/EX register
`ifndef CON_MSB
`define CON_LSB            0
`define CON_MSB            15
`define CON_REG_READ1_EN   0
`define CON_REG_READ1_NUM  1
`define CON_REG_READ2_EN   2
`define CON_REG_READ2_NUM  3
`define CON_REG_WRITE_EN   4
`define CON_REG_DST        5
`define CON_ALU_OP         9:6
`define CON_ALU_SRC        10
`define CON_IMM_SIGN       11
`define CON_MEM_READ       12
`define CON_MEM_WRITE      13
`define CON_BRANCH         14
`define CON_JUMP           15
`define CON_NOP            '0
`endif

module cpu_id_stage #(
    parameter int DATA_W = 32,
    parameter int NREG   = 32,
    parameter int CON_W  = `CON_MSB - `CON_LSB + 1,
    parameter int BYPASS = 1,
    localparam int RW    = $clog2(NREG)
) (
    input  logic              clk,
    input  logic              clr_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       current_pc,
    input  logic [31:0]       ins,
    input  logic              flush,
    input  logic              ex_load_en,
    input  logic [RW-1:0]     ex_load_num,
    input  logic              reg_write_en,
    input  logic [RW-1:0]     reg_write_num,
    input  logic [DATA_W-1:0] reg_write_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       current_pc_id,
    output logic [31:0]       ins_id,
    output logic [CON_W-1:0]  controls,
    output logic [DATA_W-1:0] reg_read1_data,
    output logic [DATA_W-1:0] reg_read2_data,
    output logic [31:0]       stall_cnt,
    output logic [DATA_W-1:0] _direct_out_v0,
    output logic [DATA_W-1:0] _direct_out_a0
);

    localparam logic [3:0] ALU_ADD = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_AND = 4'd3;
    localparam logic [3:0] ALU_OR  = 4'd4;
    localparam logic [3:0] ALU_SLT = 4'd5;
    localparam logic [3:0] ALU_LUI = 4'd6;

    logic [DATA_W-1:0] r_regs [NREG];
    logic              r_out_valid;
    logic [31:0]       r_pc;
    logic [31:0]       r_ins;
    logic [CON_W-1:0]  r_controls;
    logic [DATA_W-1:0] r_rd1;
    logic [DATA_W-1:0] r_rd2;
    logic [31:0]       r_stall_cnt;

    logic [5:0]        w_opcode;
    logic [5:0]        w_funct;
    logic [RW-1:0]     w_rs;
    logic [RW-1:0]     w_rt;
    logic [3:0]        w_r_alu;
    logic [CON_W-1:0]  w_dec;
    logic [RW-1:0]     w_sel1;
    logic [RW-1:0]     w_sel2;
    logic [DATA_W-1:0] w_rd1;
    logic [DATA_W-1:0] w_rd2;
    logic              w_hazard;
    logic              w_out_free;
    logic              w_fire;

    assign w_opcode = ins[31:26];
    assign w_funct  = ins[5:0];
    assign w_rs     = ins[21 +: RW];
    assign w_rt     = ins[16 +: RW];

    always_comb begin
        w_r_alu = 4'd0;
        case (w_funct)
            6'h20:   w_r_alu = ALU_ADD;
            6'h22:   w_r_alu = ALU_SUB;
            6'h24:   w_r_alu = ALU_AND;
            6'h25:   w_r_alu = ALU_OR;
            6'h2a:   w_r_alu = ALU_SLT;
            default: w_r_alu = 4'd0;
        endcase
    end

    // Unrecognised opcodes and functs decode to the all-zero NOP bundle.
    always_comb begin
        w_dec = `CON_NOP;
        case (w_opcode)
            6'h00: begin
                if (w_funct == 6'h08) begin
                    w_dec[`CON_REG_READ1_EN] = 1'b1;
                    w_dec[`CON_JUMP]         = 1'b1;
                end else if (w_r_alu != 4'd0) begin
                    w_dec[`CON_REG_READ1_EN]  = 1'b1;
                    w_dec[`CON_REG_READ2_EN]  = 1'b1;
                    w_dec[`CON_REG_READ2_NUM] = 1'b1;
                    w_dec[`CON_REG_WRITE_EN]  = 1'b1;
                    w_dec[`CON_ALU_OP]        = w_r_alu;
                end
            end
            6'h08, 6'h0d, 6'h23: begin
                w_dec[`CON_REG_READ1_EN] = 1'b1;
                w_dec[`CON_REG_WRITE_EN] = 1'b1;
                w_dec[`CON_REG_DST]      = 1'b1;
                w_dec[`CON_ALU_SRC]      = 1'b1;
                w_dec[`CON_ALU_OP]       = (w_opcode == 6'h0d) ? ALU_OR : ALU_ADD;
                w_dec[`CON_IMM_SIGN]     = (w_opcode != 6'h0d);
                w_dec[`CON_MEM_READ]     = (w_opcode == 6'h23);
            end
            6'h0f: begin
                w_dec[`CON_REG_WRITE_EN] = 1'b1;
                w_dec[`CON_REG_DST]      = 1'b1;
                w_dec[`CON_ALU_SRC]      = 1'b1;
                w_dec[`CON_ALU_OP]       = ALU_LUI;
            end
            6'h2b: begin
                w_dec[`CON_REG_READ1_EN]  = 1'b1;
                w_dec[`CON_REG_READ2_EN]  = 1'b1;
                w_dec[`CON_REG_READ2_NUM] = 1'b1;
                w_dec[`CON_ALU_SRC]       = 1'b1;
                w_dec[`CON_ALU_OP]        = ALU_ADD;
                w_dec[`CON_IMM_SIGN]      = 1'b1;
                w_dec[`CON_MEM_WRITE]     = 1'b1;
            end
            6'h04: begin
                w_dec[`CON_REG_READ1_EN]  = 1'b1;
                w_dec[`CON_REG_READ2_EN]  = 1'b1;
                w_dec[`CON_REG_READ2_NUM] = 1'b1;
                w_dec[`CON_ALU_OP]        = ALU_SUB;
                w_dec[`CON_IMM_SIGN]      = 1'b1;
                w_dec[`CON_BRANCH]        = 1'b1;
            end
            6'h02:   w_dec[`CON_JUMP] = 1'b1;
            default: w_dec = `CON_NOP;
        endcase
    end

    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        if (w_dec[`CON_REG_READ1_EN])
            w_sel1 = w_dec[`CON_REG_READ1_NUM] ? w_rt : w_rs;
        if (w_dec[`CON_REG_READ2_EN])
            w_sel2 = w_dec[`CON_REG_READ2_NUM] ? w_rt : w_rs;
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [RW-1:0] sel);
        if (sel == '0)
            return '0;
        if ((BYPASS != 0) && reg_write_en && (reg_write_num == sel))
            return reg_write_data;
        return r_regs[sel];
    endfunction

    always_comb begin
        w_rd1 = read_port(w_sel1);
        w_rd2 = read_port(w_sel2);
    end

    // Disabled ports select r0, and r0 is excluded, so only enabled reads can match.
    assign w_hazard   = in_valid && ex_load_en && (ex_load_num != '0) &&
                        ((w_sel1 == ex_load_num) || (w_sel2 == ex_load_num));
    assign w_out_free = !r_out_valid || out_ready;
    assign in_ready   = w_out_free && !w_hazard && !flush;
    assign w_fire     = in_valid && in_ready;

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            for (int i = 0; i < NREG; i++)
                r_regs[i] <= '0;
        end else if (reg_write_en && (reg_write_num != '0)) begin
            r_regs[reg_write_num] <= reg_write_data;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_out_valid <= 1'b0;
            r_pc        <= '0;
            r_ins       <= '0;
            r_controls  <= `CON_NOP;
            r_rd1       <= '0;
            r_rd2       <= '0;
            r_stall_cnt <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
            r_ins       <= '0;
            r_controls  <= `CON_NOP;
            r_rd1       <= '0;
            r_rd2       <= '0;
        end else if (w_fire) begin
            r_out_valid <= 1'b1;
            r_pc        <= current_pc;
            r_ins       <= ins;
            r_controls  <= w_dec;
            r_rd1       <= w_rd1;
            r_rd2       <= w_rd2;
        end else if (w_hazard && w_out_free) begin
            r_out_valid <= 1'b0;
            r_ins       <= '0;
            r_controls  <= `CON_NOP;
            if (r_stall_cnt != '1)
                r_stall_cnt <= r_stall_cnt + 32'd1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid      = r_out_valid;
    assign current_pc_id  = r_pc;
    assign ins_id         = r_ins;
    assign controls       = r_controls;
    assign reg_read1_data = r_rd1;
    assign reg_read2_data = r_rd2;
    assign stall_cnt      = r_stall_cnt;
    assign _direct_out_v0 = r_regs[2];
    assign _direct_out_a0 = r_regs[4];

endmodule

// File: tb/tb_cpu_id_stage.sv
// tb/tb_cpu_id_stage.sv - Self-checking bench for cpu_id_stage: decode table, corner sequences, random vs model
module tb_cpu_id_stage;

    localparam logic [15:0] K_R1   = 16'h0001;
    localparam logic [15:0] K_R2   = 16'h0004;
    localparam logic [15:0] K_R2RT = 16'h0008;
    localparam logic [15:0] K_WE   = 16'h0010;
    localparam logic [15:0] K_DRT  = 16'h0020;
    localparam logic [15:0] A_ADD  = 16'h0040;
    localparam logic [15:0] A_SUB  = 16'h0080;
    localparam logic [15:0] A_AND  = 16'h00C0;
    localparam logic [15:0] A_OR   = 16'h0100;
    localparam logic [15:0] A_SLT  = 16'h0140;
    localparam logic [15:0] A_LUI  = 16'h0180;
    localparam logic [15:0] K_IMM  = 16'h0400;
    localparam logic [15:0] K_SGN  = 16'h0800;
    localparam logic [15:0] K_MRD  = 16'h1000;
    localparam logic [15:0] K_MWR  = 16'h2000;
    localparam logic [15:0] K_BR   = 16'h4000;
    localparam logic [15:0] K_JMP  = 16'h8000;
    localparam logic [15:0] K_RR   = K_R1 | K_R2 | K_R2RT | K_WE;

    logic        clk = 1'b0;
    logic        clr_n, in_valid, flush, ex_load_en, reg_write_en, out_ready;
    logic [31:0] current_pc, ins, reg_write_data;
    logic [4:0]  ex_load_num, reg_write_num;

    logic        in_ready, out_valid;
    logic [31:0] pc_id, ins_id, rd1, rd2, stall, v0, a0;
    logic [15:0] ctl;
    logic        d0_in_ready, d0_out_valid;
    logic [31:0] d0_pc, d0_ins, d0_rd1, d0_rd2, d0_stall, d0_v0, d0_a0;
    logic [15:0] d0_ctl;

    always #5 clk = ~clk;

    cpu_id_stage #(.BYPASS(1)) dut (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(in_ready),
        .current_pc(current_pc), .ins(ins), .flush(flush),
        .ex_load_en(ex_load_en), .ex_load_num(ex_load_num),
        .reg_write_en(reg_write_en), .reg_write_num(reg_write_num), .reg_write_data(reg_write_data),
        .out_valid(out_valid), .out_ready(out_ready), .current_pc_id(pc_id), .ins_id(ins_id),
        .controls(ctl), .reg_read1_data(rd1), .reg_read2_data(rd2), .stall_cnt(stall),
        ._direct_out_v0(v0), ._direct_out_a0(a0)
    );

    cpu_id_stage #(.BYPASS(0)) dut0 (
        .clk(clk), .clr_n(clr_n), .in_valid(in_valid), .in_ready(d0_in_ready),
        .current_pc(current_pc), .ins(ins), .flush(flush),
        .ex_load_en(ex_load_en), .ex_load_num(ex_load_num),
        .reg_write_en(reg_write_en), .reg_write_num(reg_write_num), .reg_write_data(reg_write_data),
        .out_valid(d0_out_valid), .out_ready(out_ready), .current_pc_id(d0_pc), .ins_id(d0_ins),
        .controls(d0_ctl), .reg_read1_data(d0_rd1), .reg_read2_data(d0_rd2), .stall_cnt(d0_stall),
        ._direct_out_v0(d0_v0), ._direct_out_a0(d0_a0)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [31:0] m_regs [32];
    logic        m_valid;
    logic [31:0] m_pc, m_ins, m_op1, m_op2, m_op1n, m_op2n, m_stall;
    logic [15:0] m_ctl;

    function automatic logic [15:0] ref_ctl(input logic [31:0] w);
        case (w[31:26])
            6'h00: case (w[5:0])
                6'h20:   return K_RR | A_ADD;
                6'h22:   return K_RR | A_SUB;
                6'h24:   return K_RR | A_AND;
                6'h25:   return K_RR | A_OR;
                6'h2a:   return K_RR | A_SLT;
                6'h08:   return K_R1 | K_JMP;
                default: return 16'h0;
            endcase
            6'h08:   return K_R1 | K_WE | K_DRT | A_ADD | K_IMM | K_SGN;
            6'h0d:   return K_R1 | K_WE | K_DRT | A_OR | K_IMM;
            6'h0f:   return K_WE | K_DRT | A_LUI | K_IMM;
            6'h23:   return K_R1 | K_WE | K_DRT | A_ADD | K_IMM | K_SGN | K_MRD;
            6'h2b:   return K_R1 | K_R2 | K_R2RT | A_ADD | K_IMM | K_SGN | K_MWR;
            6'h04:   return K_R1 | K_R2 | K_R2RT | A_SUB | K_SGN | K_BR;
            6'h02:   return K_JMP;
            default: return 16'h0;
        endcase
    endfunction

    function automatic logic [4:0] ref_sel(input logic [15:0] c, input bit port2);
        logic en, use_rt;
        en     = port2 ? c[2] : c[0];
        use_rt = port2 ? c[3] : c[1];
        if (!en) return 5'd0;
        return use_rt ? ins[20:16] : ins[25:21];
    endfunction

    function automatic logic [31:0] ref_read(input logic [4:0] s, input bit byp);
        if (s == 5'd0) return 32'd0;
        if (byp && reg_write_en && reg_write_num == s) return reg_write_data;
        return m_regs[s];
    endfunction

    function automatic bit ref_hazard();
        logic [15:0] c;
        c = ref_ctl(ins);
        return in_valid && ex_load_en && ex_load_num != 5'd0 &&
               (ref_sel(c, 1'b0) == ex_load_num || ref_sel(c, 1'b1) == ex_load_num);
    endfunction

    function automatic bit ref_ready();
        return (!m_valid || out_ready) && !ref_hazard() && !flush;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
        m_valid = 0; m_pc = 0; m_ins = 0; m_ctl = 0;
        m_op1 = 0; m_op2 = 0; m_op1n = 0; m_op2n = 0; m_stall = 0;
    endtask

    task automatic model_edge();
        logic [15:0] c;
        logic [4:0]  s1, s2;
        bit          hz, rdy;
        c = ref_ctl(ins);
        s1 = ref_sel(c, 1'b0);
        s2 = ref_sel(c, 1'b1);
        hz = ref_hazard();
        rdy = ref_ready();
        if (flush) begin
            m_valid = 0; m_ctl = 0; m_ins = 0;
            m_op1 = 0; m_op2 = 0; m_op1n = 0; m_op2n = 0;
        end else if (in_valid && rdy) begin
            m_valid = 1; m_pc = current_pc; m_ins = ins; m_ctl = c;
            m_op1 = ref_read(s1, 1'b1); m_op2 = ref_read(s2, 1'b1);
            m_op1n = ref_read(s1, 1'b0); m_op2n = ref_read(s2, 1'b0);
        end else if (hz && (!m_valid || out_ready)) begin
            m_valid = 0; m_ctl = 0; m_ins = 0;
            if (m_stall != 32'hFFFF_FFFF) m_stall = m_stall + 1;
        end else if (out_ready) begin
            m_valid = 0;
        end
        if (reg_write_en && reg_write_num != 5'd0) m_regs[reg_write_num] = reg_write_data;
    endtask

    task automatic check_all();
        chk("rnd out_valid", out_valid, m_valid);
        chk("rnd pc_id", pc_id, m_pc);
        chk("rnd ins_id", ins_id, m_ins);
        chk("rnd controls", ctl, m_ctl);
        chk("rnd read1", rd1, m_op1);
        chk("rnd read2", rd2, m_op2);
        chk("rnd stall_cnt", stall, m_stall);
        chk("rnd v0", v0, m_regs[2]);
        chk("rnd a0", a0, m_regs[4]);
        chk("rnd nobyp out_valid", d0_out_valid, m_valid);
        chk("rnd nobyp ins_id", d0_ins, m_ins);
        chk("rnd nobyp pc_id", d0_pc, m_pc);
        chk("rnd nobyp controls", d0_ctl, m_ctl);
        chk("rnd nobyp read1", d0_rd1, m_op1n);
        chk("rnd nobyp read2", d0_rd2, m_op2n);
        chk("rnd nobyp stall_cnt", d0_stall, m_stall);
        chk("rnd nobyp v0", d0_v0, m_regs[2]);
        chk("rnd nobyp a0", d0_a0, m_regs[4]);
    endtask

    task automatic idle_inputs();
        in_valid = 0; flush = 0; ex_load_en = 0; ex_load_num = 0;
        reg_write_en = 0; reg_write_num = 0; reg_write_data = 0;
        current_pc = 32'h100; ins = 0; out_ready = 1;
    endtask

    task automatic do_reset();
        clr_n = 0;
        idle_inputs();
        tick();
        clr_n = 1;
        model_reset();
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [4:0]  rs, rt, rd;
        logic [15:0] im;
        rs = 5'($urandom_range(0, 7));
        rt = 5'($urandom_range(0, 7));
        rd = 5'($urandom_range(0, 7));
        im = 16'($urandom);
        case ($urandom_range(0, 13))
            0:  return {6'h00, rs, rt, rd, 5'd0, 6'h20};
            1:  return {6'h00, rs, rt, rd, 5'd0, 6'h22};
            2:  return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            3:  return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            4:  return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
            5:  return {6'h00, rs, 15'd0, 6'h08};
            6:  return {6'h08, rs, rt, im};
            7:  return {6'h0d, rs, rt, im};
            8:  return {6'h0f, 5'd0, rt, im};
            9:  return {6'h23, rs, rt, im};
            10: return {6'h2b, rs, rt, im};
            11: return {6'h04, rs, rt, im};
            12: return {6'h02, 26'($urandom)};
            default: return $urandom;
        endcase
    endfunction

    typedef struct {
        logic [31:0] word;
        logic [15:0] exp_ctl;
    } dec_vec_t;

    dec_vec_t tbl [14];

    localparam logic [31:0] I_ADD_R1R2 = 32'h0022_1820;
    localparam logic [31:0] I_SUB_R1R2 = 32'h0022_1822;
    localparam logic [31:0] I_USE_R8   = 32'h0100_4820;
    localparam logic [31:0] I_ADD_R5   = 32'h00A0_3020;
    localparam logic [31:0] I_ADD_R2   = 32'h0040_1820;

    initial begin
        tbl[0]  = '{32'h0022_1820, K_RR | A_ADD};
        tbl[1]  = '{32'h0022_1822, K_RR | A_SUB};
        tbl[2]  = '{32'h0022_1824, K_RR | A_AND};
        tbl[3]  = '{32'h0022_1825, K_RR | A_OR};
        tbl[4]  = '{32'h0022_182A, K_RR | A_SLT};
        tbl[5]  = '{32'h0020_0008, 16'h8001};
        tbl[6]  = '{32'h2022_0005, 16'h0C71};
        tbl[7]  = '{32'h3422_00FF, 16'h0531};
        tbl[8]  = '{32'h3C02_1234, 16'h05B0};
        tbl[9]  = '{32'h8C22_0004, 16'h1C71};
        tbl[10] = '{32'hAC22_0004, 16'h2C4D};
        tbl[11] = '{32'h1022_0010, 16'h488D};
        tbl[12] = '{32'h0800_0100, 16'h8000};
        tbl[13] = '{32'hFC00_0000, 16'h0000};

        // Reset state, sampled while reset is asserted and just after release
        clr_n = 0;
        idle_inputs();
        #2;
        chk("reset out_valid", out_valid, 0);
        chk("reset controls", ctl, 0);
        chk("reset ins_id", ins_id, 0);
        chk("reset pc_id", pc_id, 0);
        chk("reset read1", rd1, 0);
        chk("reset read2", rd2, 0);
        chk("reset stall_cnt", stall, 0);
        chk("reset v0", v0, 0);
        tick();
        clr_n = 1;
        model_reset();
        #1;
        chk("reset in_ready", in_ready, 1);

        // Decode table
        for (int i = 0; i < 14; i++) begin
            in_valid = 1; ins = tbl[i].word; current_pc = 32'h400 + 32'(i * 4);
            tick();
            chk("table controls", ctl, tbl[i].exp_ctl);
            chk("table ins_id", ins_id, tbl[i].word);
            chk("table pc_id", pc_id, 32'h400 + 32'(i * 4));
            chk("table out_valid", out_valid, 1);
        end

        // Same-cycle writeback bypass vs array-only read
        do_reset();
        reg_write_en = 1; reg_write_num = 5; reg_write_data = 32'h1234;
        in_valid = 1; ins = I_ADD_R5;
        tick();
        chk("bypass read1", rd1, 32'h1234);
        chk("nobypass read1", d0_rd1, 32'h0);
        reg_write_en = 0;
        tick();
        chk("bypass read1 after write", rd1, 32'h1234);
        chk("nobypass read1 after write", d0_rd1, 32'h1234);

        // Load-use bubble, then the instruction transfers
        do_reset();
        in_valid = 1; ins = I_USE_R8; ex_load_en = 1; ex_load_num = 8;
        #1 chk("hazard in_ready", in_ready, 0);
        tick();
        chk("bubble out_valid", out_valid, 0);
        chk("bubble controls", ctl, 0);
        chk("bubble ins_id", ins_id, 0);
        chk("bubble stall_cnt", stall, 1);
        ex_load_en = 0;
        #1 chk("post-bubble in_ready", in_ready, 1);
        tick();
        chk("post-bubble out_valid", out_valid, 1);
        chk("post-bubble ins_id", ins_id, I_USE_R8);
        chk("post-bubble stall_cnt", stall, 1);
        ex_load_en = 1; ex_load_num = 0; ins = 32'h0000_4820;
        #1 chk("load r0 no hazard", in_ready, 1);
        ex_load_num = 2; ins = I_ADD_R1R2;
        #1 chk("hazard on port2", in_ready, 0);
        ex_load_en = 0; in_valid = 0;
        tick();

        // Hold for three cycles, then the next instruction loads
        do_reset();
        in_valid = 1; ins = I_ADD_R1R2;
        tick();
        ins = I_SUB_R1R2; out_ready = 0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("hold in_ready", in_ready, 0);
            tick();
            chk("hold out_valid", out_valid, 1);
            chk("hold ins_id", ins_id, I_ADD_R1R2);
            chk("hold controls", ctl, K_RR | A_ADD);
        end
        out_ready = 1;
        #1 chk("release in_ready", in_ready, 1);
        tick();
        chk("release ins_id", ins_id, I_SUB_R1R2);
        in_valid = 0;
        tick();
        chk("drain out_valid", out_valid, 0);
        chk("drain ins_id kept", ins_id, I_SUB_R1R2);

        // Flush beats an incoming hazard instruction
        do_reset();
        reg_write_en = 1; reg_write_num = 1; reg_write_data = 32'h55;
        in_valid = 1; ins = I_ADD_R1R2;
        tick();
        chk("pre-flush read1", rd1, 32'h55);
        reg_write_en = 0; ins = I_USE_R8; ex_load_en = 1; ex_load_num = 8; flush = 1;
        #1 chk("flush in_ready", in_ready, 0);
        tick();
        chk("flush out_valid", out_valid, 0);
        chk("flush ins_id", ins_id, 0);
        chk("flush controls", ctl, 0);
        chk("flush read1", rd1, 0);
        chk("flush stall_cnt", stall, 0);
        flush = 0; in_valid = 0; ex_load_en = 0;
        tick();
        chk("flush dropped", out_valid, 0);

        // Asynchronous reset in the middle of a hold
        do_reset();
        reg_write_en = 1; reg_write_num = 2; reg_write_data = 32'hAAAA;
        in_valid = 1; ins = I_ADD_R2;
        tick();
        chk("pre-reset v0", v0, 32'hAAAA);
        chk("pre-reset read1", rd1, 32'hAAAA);
        reg_write_en = 0; out_ready = 0; ins = I_SUB_R1R2;
        tick();
        #1 clr_n = 0;
        #1;
        chk("async reset out_valid", out_valid, 0);
        chk("async reset read1", rd1, 0);
        chk("async reset ins_id", ins_id, 0);
        chk("async reset v0", v0, 0);
        #1 clr_n = 1;
        model_reset();
        in_valid = 0; out_ready = 1;
        tick();
        in_valid = 1; ins = I_ADD_R2;
        tick();
        chk("post-reset read1 cleared", rd1, 0);
        chk("post-reset ins_id", ins_id, I_ADD_R2);

        // Stall counter saturation
        do_reset();
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        release dut.r_stall_cnt;
        in_valid = 1; ins = I_USE_R8; ex_load_en = 1; ex_load_num = 8;
        tick();
        chk("stall reaches max", stall, 32'hFFFF_FFFF);
        tick();
        chk("stall saturates", stall, 32'hFFFF_FFFF);

        // Randomized traffic against the reference model
        do_reset();
        for (int c = 0; c < 800; c++) begin
            in_valid       = ($urandom_range(0, 3) != 0);
            ins            = rnd_ins();
            current_pc     = $urandom;
            flush          = ($urandom_range(0, 15) == 0);
            ex_load_en     = ($urandom_range(0, 2) == 0);
            ex_load_num    = 5'($urandom_range(0, 7));
            out_ready      = ($urandom_range(0, 3) != 0);
            reg_write_en   = $urandom_range(0, 1) == 1;
            reg_write_num  = 5'($urandom_range(0, 7));
            reg_write_data = $urandom;
            #1;
            chk("rnd in_ready", in_ready, ref_ready());
            chk("rnd nobyp in_ready", d0_in_ready, ref_ready());
            model_edge();
            tick();
            check_all();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
